// File: rtl/mem_access_unit_if.sv
// Data-memory bus: single outstanding req/ack transfer, word-addressed with byte enables.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a req/ack data memory; stalls the core until the access retires.
// Optional WRITE_BUFFER_EN: aligned stores are posted and drain while the core keeps running.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [1:0]         size,
  input  logic               sign_ext,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               stall,
  output logic               memfault,
  mem_access_unit_if.master  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [LANES-1:0]   be_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  readdata_reg;
  logic               we_reg;
  logic               sgn_reg;
  logic [1:0]         size_reg;

  logic               req;
  logic               misaligned;
  logic               latch_en;
  logic               capture_en;
  logic [LANES-1:0]   be_calc;
  logic [DATA_W-1:0]  wdata_calc;
  logic [DATA_W-1:0]  load_ext;
  logic [7:0]         rd_lane [LANES];
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

`ifdef WRITE_BUFFER_EN
  logic               wb_pending_reg, wb_pending_next;
  logic               posted;
`endif

  assign req        = memread | memwrite;
  assign misaligned = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));

  always_comb begin
    case (size)
      2'b00:   be_calc = 4'b0001 << addr[1:0];
      2'b01:   be_calc = 4'b0011 << {addr[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase
  end

  // Store data is replicated so the enabled lane(s) carry it regardless of offset.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdata_calc[8*gi +: 8] = (size == 2'b00) ? writedata[7:0] :
                                     (size == 2'b01) ? writedata[8*(gi%2) +: 8] :
                                                       writedata[8*gi +: 8];
      assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = rd_lane[addr_reg[1:0]];
  assign ld_half = addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_ext = {{24{sgn_reg & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{sgn_reg & ld_half[15]}}, ld_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

`ifdef WRITE_BUFFER_EN
  assign posted = (state_reg == IDLE) & memwrite & ~misaligned;
`endif

  always_comb begin
    stall = req & (state_reg != DONE) & (state_reg != FAULT);
`ifdef WRITE_BUFFER_EN
    if (posted) stall = 1'b0;
`endif
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    capture_en = 1'b0;
`ifdef WRITE_BUFFER_EN
    wb_pending_next = wb_pending_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            state_next = FAULT;
          end else begin
            state_next = BUSY;
            latch_en   = 1'b1;
            cnt_next   = '0;
`ifdef WRITE_BUFFER_EN
            wb_pending_next = memwrite;
`endif
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          capture_en = ~we_reg;
`ifdef WRITE_BUFFER_EN
          state_next      = wb_pending_reg ? IDLE : DONE;
          wb_pending_next = 1'b0;
`else
          state_next = DONE;
`endif
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // A drained posted store that times out still faults, just imprecisely.
          state_next = FAULT;
`ifdef WRITE_BUFFER_EN
          wb_pending_next = 1'b0;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      sgn_reg      <= 1'b0;
      size_reg     <= 2'b00;
      readdata_reg <= '0;
`ifdef WRITE_BUFFER_EN
      wb_pending_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
`ifdef WRITE_BUFFER_EN
      wb_pending_reg <= wb_pending_next;
`endif
      if (latch_en) begin
        addr_reg  <= addr;
        be_reg    <= be_calc;
        wdata_reg <= wdata_calc;
        we_reg    <= memwrite;
        sgn_reg   <= sign_ext;
        size_reg  <= size;
      end
      if (capture_en) readdata_reg <= load_ext;
    end
  end

  assign readdata      = readdata_reg;
  assign memfault      = (state_reg == FAULT);
  assign bus.mem_req   = (state_reg == BUSY);
  assign bus.mem_we    = (state_reg == BUSY) & we_reg;
  assign bus.mem_be    = (state_reg == BUSY) ? be_reg : '0;
  assign bus.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized loads/stores against a byte-array model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, writedata = '0;
  logic [31:0] readdata;
  logic        stall, memfault;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .size(size),
    .sign_ext(sign_ext), .addr(addr), .writedata(writedata), .readdata(readdata),
    .stall(stall), .memfault(memfault), .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [0:1023];

  // Observations of the last run_txn call
  int          obs_stall, obs_req, obs_faults;
  logic        obs_we, obs_unstable, obs_timeout, obs_end_fault, obs_end_req;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rd;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[10'(a + 32'(i))]) << (8*i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ref_load(a & ~32'd3, 4, 1'b0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input int n);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int n);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // Presents one request, plays the memory (ack on the ack_at-th req cycle, 0 = never) and records what it saw.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int ack_at);
    logic done = 1'b0;
    @(posedge clk); #1;
    memread = rd; memwrite = wr; size = sz; sign_ext = sg; addr = a; writedata = wd;
    obs_stall = 0; obs_req = 0; obs_faults = 0; obs_unstable = 1'b0; obs_timeout = 1'b0;
    obs_we = 1'b0; obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_rd = '0;
    obs_end_fault = 1'b0; obs_end_req = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (memfault) obs_faults++;
      if (bus.mem_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_we = bus.mem_we; obs_be = bus.mem_be; obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== obs_we || bus.mem_be !== obs_be ||
                     bus.mem_addr !== obs_addr || bus.mem_wdata !== obs_wdata) begin
          obs_unstable = 1'b1;
        end
        if (obs_req == ack_at) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdat; end
      end
      if (!stall) begin
        done = 1'b1; obs_rd = readdata; obs_end_fault = memfault; obs_end_req = bus.mem_req;
      end else begin
        obs_stall++;
        @(posedge clk); #1; bus.mem_ack = 1'b0;
      end
    end
    if (!done) obs_timeout = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (readdata !== 32'h0)    begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (memfault !== 1'b0)     begin errors++; $display("FAIL reset_memfault got %b want 0", memfault); end
    checks++; if (bus.mem_req !== 1'b0)  begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_be !== 4'h0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_bus got we=%b be=%h addr=%h wdata=%h want all 0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_word_load();
    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    $display("txn word_load a=100 stall_cycles=%0d rd=%h", obs_stall, obs_rd);
    checks++; if (obs_stall != 3)            begin errors++; $display("FAIL word_load_stall_cycles got %0d want 3", obs_stall); end
    checks++; if (obs_rd !== 32'hDEADBEEF)   begin errors++; $display("FAIL word_load_readdata got %h want deadbeef", obs_rd); end
    checks++; if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0)
      begin errors++; $display("FAIL word_load_bus got addr=%h be=%h we=%b want 100 f 0", obs_addr, obs_be, obs_we); end
    checks++; if (obs_unstable !== 1'b0)     begin errors++; $display("FAIL word_load_stable got unstable=%b want 0", obs_unstable); end
  endtask

  task automatic test_byte_load();
    run_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 1);
    $display("txn byte_load_signed a=103 be=%h rd=%h", obs_be, obs_rd);
    checks++; if (obs_be !== 4'b1000)        begin errors++; $display("FAIL byte_load_be got %b want 1000", obs_be); end
    checks++; if (obs_rd !== 32'hFFFFFF80)   begin errors++; $display("FAIL byte_load_signed got %h want ffffff80", obs_rd); end
    run_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 1);
    $display("txn byte_load_unsigned a=103 rd=%h", obs_rd);
    checks++; if (obs_rd !== 32'h00000080)   begin errors++; $display("FAIL byte_load_unsigned got %h want 00000080", obs_rd); end
  endtask

  task automatic test_half_store();
    run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1);
    $display("txn half_store a=102 be=%h wdata=%h", obs_be, obs_wdata);
    checks++; if (obs_we !== 1'b1)           begin errors++; $display("FAIL half_store_we got %b want 1", obs_we); end
    checks++; if (obs_be !== 4'b1100)        begin errors++; $display("FAIL half_store_be got %b want 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL half_store_wdata got %h want abcdabcd", obs_wdata); end
    checks++; if (obs_addr !== 32'h100)      begin errors++; $display("FAIL half_store_addr got %h want 100", obs_addr); end
    ref_store(32'h102, 2, 32'h1234ABCD);
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1);
    $display("txn misaligned a=101 req_cycles=%0d faults=%0d", obs_req, obs_faults);
    checks++; if (obs_req != 0)              begin errors++; $display("FAIL misaligned_req got %0d cycles want 0", obs_req); end
    checks++; if (obs_faults != 1 || obs_end_fault !== 1'b1)
      begin errors++; $display("FAIL misaligned_fault got pulses=%0d at_stall_low=%b want 1 1", obs_faults, obs_end_fault); end
    @(negedge clk);
    checks++; if (memfault !== 1'b0)         begin errors++; $display("FAIL misaligned_pulse_width got %b want 0", memfault); end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h140, 32'h0, 32'h0, 0);
    $display("txn timeout a=140 req_cycles=%0d faults=%0d", obs_req, obs_faults);
    checks++; if (obs_req != 15)             begin errors++; $display("FAIL timeout_req_cycles got %0d want 15", obs_req); end
    checks++; if (obs_faults != 1 || obs_end_fault !== 1'b1 || obs_end_req !== 1'b0)
      begin errors++; $display("FAIL timeout_fault got pulses=%0d fault=%b req=%b want 1 1 0", obs_faults, obs_end_fault, obs_end_req); end
    checks++; if (obs_timeout !== 1'b0)      begin errors++; $display("FAIL timeout_bound got expired=%b want 0", obs_timeout); end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    memread = 1'b1; size = 2'b10; addr = 32'h180;
    repeat (3) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1)      begin errors++; $display("FAIL midreset_pre_req got %b want 1", bus.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0)      begin errors++; $display("FAIL midreset_req got %b want 0", bus.mem_req); end
    checks++; if (readdata !== 32'h0)        begin errors++; $display("FAIL midreset_readdata got %h want 0", readdata); end
    memread = 1'b0;
    @(negedge clk); rst = 1'b0;
    $display("txn reset_mid_busy a=180");
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic        sg, wr, mis;
    logic [31:0] a, wd;
    int          n, ack_at;
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      n  = nbytes(sz);
      sg = 1'($urandom_range(0, 1));
`ifdef WRITE_BUFFER_EN
      wr = 1'b0;
`else
      wr = 1'($urandom_range(0, 1));
`endif
      a = 32'($urandom_range(0, 1023)) & ~32'(n - 1);
      if (n > 1 && $urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, n - 1));
      mis    = (a[1:0] & 2'(n - 1)) != 2'b00;
      wd     = $urandom;
      ack_at = int'($urandom_range(1, 4));
      run_txn(~wr, wr, sz, sg, a, wd, word_at(a), ack_at);
      $display("txn %0d %s a=%h sz=%0d mis=%b rd=%h", t, wr ? "st" : "ld", a, sz, mis, obs_rd);
      if (mis) begin
        checks++; if (obs_req != 0 || obs_faults != 1)
          begin errors++; $display("FAIL rnd_misaligned t=%0d got req=%0d faults=%0d want 0 1", t, obs_req, obs_faults); end
      end else begin
        checks++; if (obs_req != ack_at || obs_faults != 0 || obs_stall != ack_at + 1)
          begin errors++; $display("FAIL rnd_timing t=%0d got req=%0d faults=%0d stall=%0d want %0d 0 %0d", t, obs_req, obs_faults, obs_stall, ack_at, ack_at + 1); end
        checks++; if (obs_addr !== (a & ~32'd3) || obs_be !== exp_be(a, n) || obs_we !== wr || obs_unstable !== 1'b0)
          begin errors++; $display("FAIL rnd_bus t=%0d got addr=%h be=%h we=%b unstable=%b want %h %h %b 0", t, obs_addr, obs_be, obs_we, obs_unstable, a & ~32'd3, exp_be(a, n), wr); end
        if (wr) begin
          checks++; if (obs_wdata !== exp_wdata(wd, n))
            begin errors++; $display("FAIL rnd_wdata t=%0d got %h want %h", t, obs_wdata, exp_wdata(wd, n)); end
          ref_store(a, n, wd);
        end else begin
          checks++; if (obs_rd !== ref_load(a, n, sg))
            begin errors++; $display("FAIL rnd_readdata t=%0d got %h want %h", t, obs_rd, ref_load(a, n, sg)); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
`ifdef WRITE_BUFFER_EN
    int          stall_hi = 0, store_seen = 0, load_seen = 0;
    logic        done = 1'b0;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    memwrite = 1'b1; memread = 1'b0; size = 2'b10; addr = 32'h200; writedata = 32'h13579BDF;
    @(negedge clk);
    checks++; if (stall !== 1'b0)            begin errors++; $display("FAIL wb_store_stall got %b want 0", stall); end
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b1; addr = 32'h204; sign_ext = 1'b0;
    ref_store(32'h200, 4, 32'h13579BDF);
    exp_rd = ref_load(32'h204, 4, 1'b0);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) begin
        store_seen++;
        if (store_seen == 1) begin
          checks++; if (bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'h13579BDF)
            begin errors++; $display("FAIL wb_store_bus got addr=%h wdata=%h want 200 13579bdf", bus.mem_addr, bus.mem_wdata); end
        end
        bus.mem_ack = 1'b1;
      end else if (bus.mem_req) begin
        load_seen++;
        bus.mem_ack = 1'b1; bus.mem_rdata = word_at(32'h204);
      end
      if (!stall) begin
        done = 1'b1;
        checks++; if (readdata !== exp_rd)   begin errors++; $display("FAIL wb_load_readdata got %h want %h", readdata, exp_rd); end
      end else stall_hi++;
      @(posedge clk); #1; bus.mem_ack = 1'b0;
    end
    memread = 1'b0;
    $display("txn wb_back_to_back stall_cycles=%0d stores=%0d loads=%0d", stall_hi, store_seen, load_seen);
    checks++; if (!done || stall_hi != 3 || store_seen != 1 || load_seen != 1)
      begin errors++; $display("FAIL wb_sequence got done=%b stall=%0d stores=%0d loads=%0d want 1 3 1 1", done, stall_hi, store_seen, load_seen); end
`else
    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1);
    ref_store(32'h300, 4, 32'hCAFEF00D);
    $display("txn b2b_store a=300 stall_cycles=%0d", obs_stall);
    checks++; if (obs_stall != 2 || obs_wdata !== 32'hCAFEF00D)
      begin errors++; $display("FAIL b2b_store got stall=%0d wdata=%h want 2 cafef00d", obs_stall, obs_wdata); end
    run_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, word_at(32'h300), 1);
    $display("txn b2b_load a=302 rd=%h", obs_rd);
    checks++; if (obs_rd !== 32'hFFFFCAFE)   begin errors++; $display("FAIL b2b_load got %h want ffffcafe", obs_rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    test_reset();
    test_word_load();
    test_byte_load();
`ifndef WRITE_BUFFER_EN
    test_half_store();
`endif
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
